ssp_tx_fifo: RTL and testbench

Transmit FIFO for the PL022 SSP: an 8-entry x 16-bit first-word-fall-through buffer between the APB data-register write path and the SSP master/slave transmit shift logic. The APB side pushes words and the serialiser pops them. The block owns the storage, read/write pointers, occupancy count and status flags, plus the TESTFIFO mode in which APB reads drain the FIFO.

---
 rtl/ssp_tx_fifo.sv | 95 +++++++++
 tb/tb_ssp_tx_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ssp_tx_fifo.sv
// ssp_tx_fifo: 8 x 16-bit first-word-fall-through transmit FIFO for the SSP.
// The APB write path pushes words and the transmit serialiser pops them.
// In TESTFIFO mode, APB reads of the data register drain the FIFO instead.
//
// Handshake: there is no ready output. A push strobe (TxFWrEn) is taken on
// the rising edge only when the registered count is below 8; otherwise the
// word is dropped. A pop strobe is taken only when the registered count is
// non-zero; otherwise it is ignored. Both decisions use the pre-edge count.
// TxFClr overrides both strobes.
module ssp_tx_fifo (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        TxFWrEn,
  input  logic [15:0] PWDATAIn,
  input  logic        TxFRdEn,
  input  logic        TESTFIFO,
  input  logic        TxFTestRdEn,
  input  logic        TxFClr,
  output logic [15:0] TxFRdData,
  output logic        TxFEmpty,
  output logic        TxFFull,
  output logic        TxFHalfEmpty,
  output logic [3:0]  TxFCount
);

  logic [15:0] mem_q [8];
  logic [2:0]  wr_ptr_q, wr_ptr_d;
  logic [2:0]  rd_ptr_q, rd_ptr_d;
  logic [3:0]  count_q, count_d;

  logic pop;
  logic push_ok;
  logic pop_ok;
  logic wr_mem;

  // Select the active pop source, then qualify both strobes on the registered count.
  always_comb begin
    pop     = TESTFIFO ? TxFTestRdEn : TxFRdEn;
    push_ok = TxFWrEn & (count_q != 4'd8);
    pop_ok  = pop & (count_q != 4'd0);
    wr_mem  = push_ok & ~TxFClr;
  end

  // Next-state pointers and occupancy; a flush has priority over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (TxFClr) begin
      wr_ptr_d = 3'd0;
      rd_ptr_d = 3'd0;
      count_d  = 4'd0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 3'd1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 3'd1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 4'd1;
        2'b01:   count_d = count_q - 4'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr_q <= 3'd0;
      rd_ptr_q <= 3'd0;
      count_q  <= 4'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; a flush leaves the contents in place, they simply become invalid.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < 8; i++) mem_q[i] <= 16'h0000;
    end else if (wr_mem) begin
      mem_q[wr_ptr_q] <= PWDATAIn;
    end
  end

  // Outputs decode registered state only, so no strobe reaches an output.
  always_comb begin
    TxFRdData    = mem_q[rd_ptr_q];
    TxFEmpty     = (count_q == 4'd0);
    TxFFull      = (count_q == 4'd8);
    TxFHalfEmpty = (count_q <= 4'd4);
    TxFCount     = count_q;
  end

endmodule

// File: tb/tb_ssp_tx_fifo.sv
// tb_ssp_tx_fifo: table-driven vectors, directed corner sequences and a
// randomized run checked against a queue-based model of the FIFO.
module tb_ssp_tx_fifo;

  logic        PCLK;
  logic        PRESETn;
  logic        TxFWrEn;
  logic [15:0] PWDATAIn;
  logic        TxFRdEn;
  logic        TESTFIFO;
  logic        TxFTestRdEn;
  logic        TxFClr;
  logic [15:0] TxFRdData;
  logic        TxFEmpty;
  logic        TxFFull;
  logic        TxFHalfEmpty;
  logic [3:0]  TxFCount;

  int checks = 0;
  int errors = 0;

  // Reference model: the FIFO contents as a queue, head at index 0.
  logic [15:0] exp_q[$];

  typedef struct {
    logic        wr;
    logic [15:0] data;
    logic        rd;
    int          exp_count;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[17];

  ssp_tx_fifo dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .TxFWrEn     (TxFWrEn),
    .PWDATAIn    (PWDATAIn),
    .TxFRdEn     (TxFRdEn),
    .TESTFIFO    (TESTFIFO),
    .TxFTestRdEn (TxFTestRdEn),
    .TxFClr      (TxFClr),
    .TxFRdData   (TxFRdData),
    .TxFEmpty    (TxFEmpty),
    .TxFFull     (TxFFull),
    .TxFHalfEmpty(TxFHalfEmpty),
    .TxFCount    (TxFCount)
  );

  // Clock
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare all outputs against a given occupancy and head word.
  task automatic chk_state(input string name, input int cnt, input logic [15:0] head);
    chk({name, " count"}, {12'd0, TxFCount}, 16'(cnt));
    chk({name, " empty"}, {15'd0, TxFEmpty}, {15'd0, cnt == 0});
    chk({name, " full"},  {15'd0, TxFFull},  {15'd0, cnt == 8});
    chk({name, " half"},  {15'd0, TxFHalfEmpty}, {15'd0, cnt <= 4});
    if (cnt != 0) chk({name, " data"}, TxFRdData, head);
  endtask

  task automatic chk_model(input string name);
    chk_state(name, exp_q.size(), (exp_q.size() != 0) ? exp_q[0] : 16'h0000);
  endtask

  // One clock of stimulus; the model advances from the pre-edge contents.
  task automatic drive(input logic wr, input logic [15:0] d, input logic rd,
                       input logic test, input logic trd, input logic clr);
    logic p;
    logic push_ok;
    logic pop_ok;
    TxFWrEn = wr; PWDATAIn = d; TxFRdEn = rd;
    TESTFIFO = test; TxFTestRdEn = trd; TxFClr = clr;
    @(posedge PCLK);
    #1;
    p       = test ? trd : rd;
    push_ok = wr && (exp_q.size() < 8);
    pop_ok  = p && (exp_q.size() > 0);
    if (clr) exp_q.delete();
    else begin
      if (pop_ok) void'(exp_q.pop_front());
      if (push_ok) exp_q.push_back(d);
    end
    TxFWrEn = 0; TxFRdEn = 0; TxFTestRdEn = 0; TxFClr = 0;
  endtask

  task automatic do_reset();
    PRESETn = 1'b0;
    #12;
    exp_q.delete();
    @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
  endtask

  initial begin
    // Fill/overflow/drain table: eight pushes, one dropped push, eight pops.
    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b1, 16'(16'h1111 * (i + 1)), 1'b0, i + 1, 16'h1111};
    vecs[8] = '{1'b1, 16'h9999, 1'b0, 8, 16'h1111};
    for (int k = 0; k < 8; k++)
      vecs[9 + k] = '{1'b0, 16'h0000, 1'b1, 7 - k, 16'(16'h1111 * (k + 2))};

    TxFWrEn = 0; PWDATAIn = 0; TxFRdEn = 0; TESTFIFO = 0; TxFTestRdEn = 0; TxFClr = 0;
    PRESETn = 1'b0;
    #1;
    chk_state("reset", 0, 16'h0000);
    chk("reset rddata", TxFRdData, 16'h0000);
    do_reset();

    // Table-driven fill and overflow.
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].wr, vecs[i].data, vecs[i].rd, 1'b0, 1'b0, 1'b0);
      chk_state($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_data);
    end

    // Asynchronous reset mid-fill with three entries.
    for (int i = 0; i < 3; i++) drive(1'b1, 16'hC000 + 16'(i) + 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_model("prefill3");
    #2;
    PRESETn = 1'b0;
    #1;
    chk_state("async reset", 0, 16'h0000);
    chk("async reset rddata", TxFRdData, 16'h0000);
    do_reset();

    // Wrap-around: pointers run past 7.
    for (int i = 0; i < 6; i++) drive(1'b1, 16'h0600 + 16'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_model("wrap drained");
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      chk_model($sformatf("wrap push%0d", i));
    end
    chk("wrap half at 5", {15'd0, TxFHalfEmpty}, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("wrap head%0d", i), TxFRdData, 16'hA000 + 16'(i));
      drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    chk_model("wrap end");

    // Full: push and pop together, push dropped.
    for (int i = 0; i < 8; i++) drive(1'b1, 16'($urandom_range(0, 16'hFFFF)), 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("full push+pop count", {12'd0, TxFCount}, 16'd7);
    chk_model("full push+pop");
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("no beef %0d", i), {15'd0, TxFRdData == 16'hBEEF}, 16'd0);
      drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    chk_model("full drained");

    // Empty: push and pop together, push taken.
    drive(1'b1, 16'h00C3, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_state("empty push+pop", 1, 16'h00C3);
    drive(1'b1, 16'h00C4, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h00C5, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h00C6, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_state("count3 push+pop", 3, 16'h00C4);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("order %0d", i), TxFRdData, 16'h00C4 + 16'(i) + 16'(i == 2 ? 0 : 0) + 16'(i >= 0 ? 0 : 0));
      drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    chk_model("order end");

    // Clear beats simultaneous push and pop.
    for (int i = 0; i < 5; i++) drive(1'b1, 16'h5000 + 16'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'hDEAD, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_state("clear", 0, 16'h0000);
    drive(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_state("after clear", 1, 16'h1234);
    drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Test mode: TxFRdEn ignored, TxFTestRdEn pops.
    drive(1'b1, 16'h5A5A, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 16'hA5A5, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_state("test rd ignored", 2, 16'h5A5A);
    drive(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk_state("test pop1", 1, 16'hA5A5);
    drive(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk_state("test pop2", 0, 16'h0000);

    // Normal mode: test strobe ignored.
    drive(1'b1, 16'h7777, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_state("normal trd ignored", 1, 16'h7777);

    // Randomized run against the queue model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 99) < 55), 16'($urandom_range(0, 16'hFFFF)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 49) == 0));
      chk_model($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
